uart_tx_queue: RTL and testbench

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_tx_queue_pkg.sv | 30 +++
 rtl/uart_tx_queue_byte_fifo.sv | 65 ++++++
 rtl/uart_tx_queue.sv | 92 +++++++++
 tb/tb_uart_tx_queue.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_queue_pkg.sv
// uart_tx_queue_pkg
//   Shared definitions for the UART transmit queue:
//   - state_t and the ST_* state encodings of the transmit FSM
//   - ptr_w()/cnt_w() helpers that derive pointer and count widths from DEPTH
//   - default parameter values and the derived default widths
package uart_tx_queue_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOAD      = 3'd1;
  localparam state_t ST_START     = 3'd2;
  localparam state_t ST_WAIT_BUSY = 3'd3;
  localparam state_t ST_WAIT_DONE = 3'd4;

  // Pointer width indexes DEPTH entries; count needs one more bit to hold DEPTH.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEFAULT_DEPTH       = 16;
  localparam int DEFAULT_ACK_TIMEOUT = 4;
  localparam int DEFAULT_PTR_W       = ptr_w(DEFAULT_DEPTH);
  localparam int DEFAULT_CNT_W       = cnt_w(DEFAULT_DEPTH);

endpackage

// File: rtl/uart_tx_queue_byte_fifo.sv
// byte_fifo
//   Byte-wide synchronous FIFO, DEPTH entries (power of two), pointers wrap
//   modulo DEPTH.
//   Ports:
//     clk, rst            - clock, synchronous active-high reset
//     wr_en, wr_data      - write strobe and byte
//     rd_en               - pop strobe (head advances on this edge)
//     rd_data             - current head byte (valid while !empty)
//     count, full, empty  - occupancy status, updated on the edge after a write/pop
//   A write while full is accepted only if a pop happens on the same edge.
import uart_tx_queue_pkg::*;

module byte_fifo #(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [7:0]              wr_data,
  input  logic                    rd_en,
  output logic [7:0]              rd_data,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             rd_ok;
  logic             wr_ok;

  assign rd_ok = rd_en && !empty;
  // When full, the slot freed by a same-edge pop takes the new byte.
  assign wr_ok = wr_en && (!full || rd_ok);

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue
//   Queues bytes from an upstream producer and hands them one at a time to a
//   UART transmitter.
//   Ports:
//     sys_clk, rst        - clock, synchronous active-high reset
//     data_in, wr_en      - byte to enqueue, one byte per high wr_en cycle
//     busy_flag           - UART transmitter busy while a frame shifts out
//     tx_data, tx_en      - byte to send and its single-cycle start pulse
//     count, full, empty  - queue occupancy
//     overflow            - sticky, set when a write is dropped; cleared by rst
//     state_dbg           - current FSM state (ST_* encodings)
//   Handshake: tx_en is high for exactly one cycle (START) with tx_data stable;
//   the transmitter acknowledges by raising busy_flag, and the next byte is
//   only loaded once busy_flag has fallen again. If busy_flag never rises
//   within ACK_TIMEOUT cycles the byte counts as sent and is not retried.
import uart_tx_queue_pkg::*;

module uart_tx_queue #(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic [7:0]              data_in,
  input  logic                    wr_en,
  input  logic                    busy_flag,
  output logic [7:0]              tx_data,
  output logic                    tx_en,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output state_t                  state_dbg
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] timer;
  logic             pop;
  logic [7:0]       head;

  assign pop       = (state == ST_LOAD);
  assign tx_en     = (state == ST_START);
  assign state_dbg = state;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (sys_clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (data_in),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (!empty && !busy_flag) state_nxt = ST_LOAD;
      ST_LOAD:      state_nxt = ST_START;
      ST_START:     state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (busy_flag)                               state_nxt = ST_WAIT_DONE;
        else if (timer == TMR_W'(ACK_TIMEOUT - 1))   state_nxt = ST_IDLE;
      end
      ST_WAIT_DONE: if (!busy_flag) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      timer    <= '0;
      tx_data  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      // Timer counts cycles spent in WAIT_BUSY; cleared on the way in.
      if (state == ST_WAIT_BUSY) timer <= timer + 1'b1;
      else                       timer <= '0;
      if (pop) tx_data <= head;
      // A write while full is dropped unless the LOAD pop frees a slot.
      if (wr_en && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue
//   Directed bench for uart_tx_queue: expected bytes are pushed into exp_q as
//   they are written; a monitor pops and compares whenever tx_en is seen.
module tb_uart_tx_queue;
  import uart_tx_queue_pkg::*;

  localparam int DEPTH = 16;

  logic       sys_clk;
  logic       rst;
  logic [7:0] data_in;
  logic       wr_en;
  logic       busy_flag;
  logic [7:0] tx_data;
  logic       tx_en;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  state_t     state_dbg;

  // busy model controls
  logic model_busy;
  logic force_busy;
  logic ack_enable;
  int   busy_len;

  assign busy_flag = model_busy | force_busy;

  int checks;
  int errors;
  int tx_count;
  logic [7:0] exp_q[$];

  uart_tx_queue #(.DEPTH(DEPTH), .ACK_TIMEOUT(4)) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .data_in   (data_in),
    .wr_en     (wr_en),
    .busy_flag (busy_flag),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge sys_clk);
      if (tx_en === 1'b1) begin
        tx_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tx: tx_data 0x%0h with no byte expected", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL tx_byte: got 0x%0h expected 0x%0h", tx_data, e);
          end
        end
      end
    end
  end

  // UART transmitter model: busy rises the cycle after tx_en, for busy_len cycles
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (tx_en === 1'b1 && ack_enable) begin
        model_busy = 1'b1;
        repeat (busy_len) @(negedge sys_clk);
        model_busy = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic write_byte(input logic [7:0] b, input bit expect_kept);
    data_in = b;
    wr_en   = 1'b1;
    if (expect_kept) exp_q.push_back(b);
    @(negedge sys_clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_state(input state_t s, input int budget, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge sys_clk);
      if (state_dbg == s) found = 1'b1;
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge sys_clk);
      if (exp_q.size() == 0 && state_dbg == ST_IDLE && !busy_flag) done = 1'b1;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_tx_en(input int budget, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge sys_clk);
      if (tx_en === 1'b1) found = 1'b1;
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  initial begin
    int tx_before;
    int gap;
    checks = 0; errors = 0; tx_count = 0;
    rst = 1'b1; wr_en = 1'b0; data_in = 8'h00;
    force_busy = 1'b0; ack_enable = 1'b1; busy_len = 10;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;

    // reset state
    check("rst_count",    32'(count),     32'd0);
    check("rst_empty",    32'(empty),     32'd1);
    check("rst_full",     32'(full),      32'd0);
    check("rst_overflow", 32'(overflow),  32'd0);
    check("rst_tx_en",    32'(tx_en),     32'd0);
    check("rst_tx_data",  32'(tx_data),   32'h00);
    check("rst_state",    32'(state_dbg), 32'(ST_IDLE));

    // single byte: tx_en in the cycle after E+2
    write_byte(8'hA5, 1'b1);            // now just after edge E
    check("single_count1", 32'(count), 32'd1);
    @(negedge sys_clk);                 // after E+1 (LOAD)
    check("single_no_tx_early", 32'(tx_en), 32'd0);
    @(negedge sys_clk);                 // after E+2 (START)
    check("single_tx_en", 32'(tx_en), 32'd1);
    check("single_count0", 32'(count), 32'd0);
    wait_drain(100, "single_drain");
    check("single_tx_data_hold", 32'(tx_data), 32'hA5);

    // burst of 16 with busy held: fills, no tx_en
    force_busy = 1'b1;
    tx_before  = tx_count;
    for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b1);
    repeat (3) @(negedge sys_clk);
    check("burst_full",  32'(full),  32'd1);
    check("burst_count", 32'(count), 32'd16);
    check("burst_no_tx", 32'(tx_count), 32'(tx_before));

    // release busy; write on the LOAD edge at count==16
    force_busy = 1'b0;
    wait_state(ST_LOAD, 10, "wait_load");
    data_in = 8'h10; wr_en = 1'b1; exp_q.push_back(8'h10);
    @(negedge sys_clk);                 // START: pop and write shared an edge
    check("simul_count",    32'(count),    32'd16);
    check("simul_overflow", 32'(overflow), 32'd0);
    // 17th write while full with no pop: dropped
    data_in = 8'hEE;
    @(negedge sys_clk);
    wr_en = 1'b0;
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_count", 32'(count),    32'd16);
    check("ovf_full",  32'(full),     32'd1);
    wait_drain(1000, "burst_drain");
    check("burst_empty", 32'(empty), 32'd1);
    check("ovf_sticky",  32'(overflow), 32'd1);

    // no acknowledge: timeout after 4 cycles, next byte follows
    ack_enable = 1'b0;
    write_byte(8'h5A, 1'b1);
    write_byte(8'h3C, 1'b1);
    wait_tx_en(10, "noack_first_tx");
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      gap++;
      if (tx_en === 1'b1) break;
    end
    check("noack_gap", 32'(gap), 32'd7);
    wait_drain(100, "noack_drain");
    ack_enable = 1'b1;

    // reset in WAIT_DONE with 5 bytes queued
    busy_len = 20;
    write_byte(8'h61, 1'b1);
    for (int i = 2; i <= 6; i++) write_byte(8'(8'h60 + i), 1'b0);
    wait_state(ST_WAIT_DONE, 10, "wait_done");
    check("pre_rst_count", 32'(count), 32'd5);
    tx_before = tx_count;
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    check("mid_rst_count",    32'(count),     32'd0);
    check("mid_rst_empty",    32'(empty),     32'd1);
    check("mid_rst_tx_en",    32'(tx_en),     32'd0);
    check("mid_rst_overflow", 32'(overflow),  32'd0);
    check("mid_rst_tx_data",  32'(tx_data),   32'h00);
    check("mid_rst_state",    32'(state_dbg), 32'(ST_IDLE));
    repeat (40) @(negedge sys_clk);
    check("mid_rst_no_tx", 32'(tx_count), 32'(tx_before));

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
